// File: rtl/mult_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_unit
//  Purpose  : Multi-cycle shift-add integer multiplier (MULT/MULTU) with
//             architectural HI/LO registers and MTHI/MTLO write support.
//             One multiplier bit is retired per clock; the magnitude product
//             is sign-corrected once at the end.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dat_a,
    input  logic [WIDTH-1:0] i_dat_b,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wr_dat,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    // Counter only has to reach WIDTH-1, so log2(WIDTH) bits suffice.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               neg_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_neg;

    // Magnitudes are taken as unsigned WIDTH-bit values, so the most negative
    // operand maps onto its correct magnitude 2^(WIDTH-1).
    assign w_abs_a   = (i_signed && i_dat_a[WIDTH-1]) ? (~i_dat_a + 1'b1) : i_dat_a;
    assign w_abs_b   = (i_signed && i_dat_b[WIDTH-1]) ? (~i_dat_b + 1'b1) : i_dat_b;
    assign w_acc_neg = ~acc_q + 1'b1;

    // State and registered status flags; reset aborts any operation at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: IDLE -> CALC on start, WIDTH CALC cycles, one FINISH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (i_start) state_d = S_CALC;
            S_CALC:   if (cnt_q == C_LAST) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: flags are computed one cycle early and registered, so
    // o_busy has no combinational path from i_start.
    always_comb begin
        busy_d = (state_d == S_CALC) || (state_d == S_FINISH);
        done_d = (state_q == S_FINISH);
    end

    // Datapath: operand capture, shift-add iteration, HI/LO updates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Register writes are only honoured while idle.
                    if (i_wr_hi) hi_q <= i_wr_dat;
                    if (i_wr_lo) lo_q <= i_wr_dat;
                    if (i_start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, w_abs_a};
                        mplier_q <= w_abs_b;
                        neg_q    <= i_signed & (i_dat_a[WIDTH-1] ^ i_dat_b[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                S_CALC: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                end
                S_FINISH: begin
                    {hi_q, lo_q} <= neg_q ? w_acc_neg : acc_q;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_unit
//  Purpose  : Self-checking bench for mult_unit; expected products are queued
//             at start time and compared when o_done is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] dat_a, dat_b;
    logic             wr_hi, wr_lo;
    logic [WIDTH-1:0] wr_dat;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    mult_unit #(.WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_signed (sgn),
        .i_dat_a  (dat_a),
        .i_dat_b  (dat_b),
        .i_wr_hi  (wr_hi),
        .i_wr_lo  (wr_lo),
        .i_wr_dat (wr_dat),
        .o_busy   (busy),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic s);
        logic signed [2*WIDTH-1:0] sa, sb;
        logic [2*WIDTH-1:0] ua, ub;
        if (s) begin
            sa = {{WIDTH{a[WIDTH-1]}}, a};
            sb = {{WIDTH{b[WIDTH-1]}}, b};
            return sa * sb;
        end
        ua = {{WIDTH{1'b0}}, a};
        ub = {{WIDTH{1'b0}}, b};
        return ua * ub;
    endfunction

    // Drive a start at the next negedge; return 1 ns after the sampling edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s, input bit expect_it);
        @(negedge clk);
        start = 1'b1; sgn = s; dat_a = a; dat_b = b;
        if (expect_it) exp_q.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        start = 1'b0;
        dat_a = $urandom;
        dat_b = $urandom;
        sgn   = $urandom_range(0, 1);
    endtask

    // Step until o_done, counting cycles since the start edge and busy cycles.
    task automatic wait_done(input int cyc0, output int cyc, output int busy_cnt, output bit to);
        cyc = cyc0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cnt++;
        end
        to = !done;
    endtask

    task automatic pop_exp(output logic [2*WIDTH-1:0] e);
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; sgn = 0; dat_a = 0; dat_b = 0;
        wr_hi = 0; wr_lo = 0; wr_dat = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({hi, lo, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, required all zero", hi, lo, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_multu_small;
        int cyc, bc; bit to; logic [2*WIDTH-1:0] e;
        start_op(32'd6, 32'd7, 1'b0, 1'b1);
        wait_done(0, cyc, bc, to);
        checks++;
        if (to) begin errors++; $display("FAIL multu_small_timeout: no o_done within %0d cycles", cyc); end
        checks++;
        if (cyc !== LAT) begin errors++; $display("FAIL multu_small_latency: got %0d, required %0d", cyc, LAT); end
        checks++;
        if (bc !== LAT) begin errors++; $display("FAIL multu_small_busy_cycles: got %0d, required %0d", bc, LAT); end
        pop_exp(e);
        checks++;
        if ({hi, lo} !== e || lo !== 32'h2A) begin
            errors++; $display("FAIL multu_small_result: got %h_%h, required %h", hi, lo, e);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done=%b, required 0", done); end
    endtask

    task automatic test_multu_max;
        int cyc, bc; bit to; logic [2*WIDTH-1:0] e;
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done(0, cyc, bc, to);
        pop_exp(e);
        checks++;
        if (to || {hi, lo} !== e || hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
            errors++; $display("FAIL multu_max: got %h_%h to=%b, required %h", hi, lo, to, e);
        end
    endtask

    task automatic test_signed;
        logic [WIDTH-1:0] ta[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [WIDTH-1:0] tb[4] = '{32'd5,        32'h8000_0000, 32'd1,         32'hFFFF_FFFF};
        int cyc, bc; bit to; logic [2*WIDTH-1:0] e;
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i], 1'b1, 1'b1);
            wait_done(0, cyc, bc, to);
            pop_exp(e);
            checks++;
            if (to || {hi, lo} !== e) begin
                errors++; $display("FAIL mult_signed_%0d: got %h_%h to=%b, required %h", i, hi, lo, to, e);
            end
        end
    endtask

    task automatic test_random;
        int cyc, bc; bit to; logic [2*WIDTH-1:0] e;
        logic [WIDTH-1:0] a, b; logic s;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; s = i[0];
            start_op(a, b, s, 1'b1);
            wait_done(0, cyc, bc, to);
            pop_exp(e);
            checks++;
            if (to || {hi, lo} !== e) begin
                errors++; $display("FAIL random_%0d: a=%h b=%h s=%b got %h_%h, required %h", i, a, b, s, hi, lo, e);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int cyc, bc; bit to; logic [2*WIDTH-1:0] e;
        logic [WIDTH-1:0] hi0;
        hi0 = hi;
        start_op(32'd1000, 32'd3000, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dat_a = 32'd9; dat_b = 32'd9; sgn = 1'b0;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_dat = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        checks++;
        if (hi !== hi0) begin errors++; $display("FAIL busy_write_hi: hi=%h, required %h", hi, hi0); end
        wait_done(5, cyc, bc, to);
        checks++;
        if (to || cyc !== LAT) begin errors++; $display("FAIL busy_latency: got %0d to=%b, required %0d", cyc, to, LAT); end
        pop_exp(e);
        checks++;
        if ({hi, lo} !== e) begin errors++; $display("FAIL busy_first_result: got %h_%h, required %h", hi, lo, e); end
        repeat (LAT + 3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== e) begin
            errors++; $display("FAIL busy_start_ignored: busy=%b hi_lo=%h_%h, required 0 and %h", busy, hi, lo, e);
        end
    endtask

    task automatic test_hilo_write;
        logic [WIDTH-1:0] hi0;
        hi0 = hi;
        @(negedge clk);
        wr_lo = 1'b1; wr_dat = 32'hABCD;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        checks++;
        if (lo !== 32'h0000_ABCD || hi !== hi0) begin
            errors++; $display("FAIL mtlo: hi=%h lo=%h, required %h and 0000abcd", hi, lo, hi0);
        end
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wr_dat = 32'h5A5A_0F0F;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        checks++;
        if (hi !== 32'h5A5A_0F0F || lo !== 32'h5A5A_0F0F) begin
            errors++; $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required 5a5a0f0f", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc; bit to; logic [2*WIDTH-1:0] e;
        start_op(32'd12345, 32'd678, 1'b0, 1'b1);
        wait_done(0, cyc, bc, to);
        pop_exp(e);
        checks++;
        if (to || {hi, lo} !== e) begin errors++; $display("FAIL b2b_first: got %h_%h, required %h", hi, lo, e); end
        start_op(32'hFFFF_FFF0, 32'd16, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b, required 1", busy); end
        wait_done(0, cyc, bc, to);
        pop_exp(e);
        checks++;
        if (to || cyc !== LAT || {hi, lo} !== e) begin
            errors++; $display("FAIL b2b_second: cyc=%0d got %h_%h, required %0d and %h", cyc, hi, lo, LAT, e);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bc; bit to; logic [2*WIDTH-1:0] e;
        bit seen;
        start_op(32'd6, 32'd7, 1'b0, 1'b1);
        void'(exp_q.pop_back());
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hi, lo, busy, done} !== '0) begin
            errors++; $display("FAIL reset_mid_async: hi=%h lo=%h busy=%b done=%b, required all zero", hi, lo, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (done || busy || hi !== '0 || lo !== '0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_mid_no_done: activity=%b, required 0", seen); end
        start_op(32'd6, 32'd7, 1'b0, 1'b1);
        wait_done(0, cyc, bc, to);
        pop_exp(e);
        checks++;
        if (to || cyc !== LAT || {hi, lo} !== e) begin
            errors++; $display("FAIL reset_mid_restart: cyc=%0d got %h_%h, required %0d and %h", cyc, hi, lo, LAT, e);
        end
    endtask

    initial begin
        test_reset();
        test_multu_small();
        test_multu_max();
        test_signed();
        test_random();
        test_busy_ignore();
        test_hilo_write();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
